// File: rtl/mmcm_phase_cntr_pkg.sv
// Shared definitions for the MMCM dynamic fine phase-shift initiator.
package mmcm_phase_cntr_pkg;

    // Controller states.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        STEP      = 2'd2,
        WAIT_DONE = 2'd3
    } ps_state_t;

    // psclk cycles from psen to psdone inside the MMCME2_ADV.
    localparam int MMCM_PS_LATENCY = 12;

    // Default psdone watchdog, comfortably above the MMCM latency.
    localparam int PSDONE_TIMEOUT_DEFAULT = 31;

    // Width of a counter that must hold values 0..timeout.
    function automatic int timeout_cnt_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mmcm_phase_cntr.sv
// Initiator for the MMCME2_ADV dynamic fine phase-shift port. Walks the
// MMCM one fine step at a time toward a signed target phase and tracks
// the phase actually applied.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_LOCK | MMCM unlocked; applied phase is the static (zero) phase
//   IDLE      | locked; decide whether another step toward target is due
//   STEP      | psen pulse on the MMCM port, direction latched on psincdec
//   WAIT_DONE | waiting for psdone, bounded by the timeout counter
module mmcm_phase_cntr
    import mmcm_phase_cntr_pkg::*;
#(
    parameter int PHASE_WIDTH    = 8,
    parameter int PSDONE_TIMEOUT = PSDONE_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          locked,
    input  logic                          ps_we,
    input  logic signed [PHASE_WIDTH-1:0] ps_target,
    output logic signed [PHASE_WIDTH-1:0] ps_phase,
    output logic                          ps_ready,
    output logic                          ps_err,
    output logic                          psen,
    output logic                          psincdec,
    input  logic                          psdone
);

    localparam int CNT_W = timeout_cnt_width(PSDONE_TIMEOUT);

    // The counter holds the number of cycles elapsed since psen was high,
    // so the last value before timing out is PSDONE_TIMEOUT-1.
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PSDONE_TIMEOUT - 1);

    localparam logic signed [PHASE_WIDTH-1:0] PHASE_ONE = PHASE_WIDTH'(1);

    // A watchdog shorter than the MMCM latency would fire on every step.
    if (PSDONE_TIMEOUT < MMCM_PS_LATENCY) begin : g_bad_timeout
        $error("PSDONE_TIMEOUT must not be shorter than the MMCM phase-shift latency");
    end

    ps_state_t                   state;
    logic signed [PHASE_WIDTH-1:0] target;
    logic [CNT_W-1:0]            cnt;

    // Controller FSM with registered MMCM strobes, phase tracking and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            target   <= '0;
            ps_phase <= '0;
            psen     <= 1'b0;
            psincdec <= 1'b0;
            ps_err   <= 1'b0;
            ps_ready <= 1'b0;
            cnt      <= '0;
        end else begin
            psen     <= 1'b0;
            ps_ready <= (state == IDLE) && (target == ps_phase) && locked;

            // A new target is picked up at the next IDLE decision; an
            // in-flight step is never cut short by it. A timeout raised in
            // the same cycle overrides the clear below.
            if (ps_we) begin
                target <= ps_target;
                ps_err <= 1'b0;
            end

            if ((state != WAIT_LOCK) && !locked) begin
                // Losing lock returns the MMCM to its static phase; any
                // psdone seen in this cycle belongs to an abandoned step.
                state    <= WAIT_LOCK;
                ps_phase <= '0;
                cnt      <= '0;
            end else begin
                unique case (state)
                    WAIT_LOCK: begin
                        if (locked) begin
                            state <= IDLE;
                        end
                    end

                    IDLE: begin
                        // psen and the direction are registered here so that
                        // both are on the MMCM port for the whole STEP cycle.
                        if (target != ps_phase) begin
                            state    <= STEP;
                            psen     <= 1'b1;
                            psincdec <= (target > ps_phase);
                        end
                    end

                    STEP: begin
                        state <= WAIT_DONE;
                        cnt   <= CNT_ONE;
                    end

                    WAIT_DONE: begin
                        if (psdone) begin
                            ps_phase <= psincdec ? (ps_phase + PHASE_ONE)
                                                 : (ps_phase - PHASE_ONE);
                            state    <= IDLE;
                            cnt      <= '0;
                        end else if (cnt == CNT_LAST) begin
                            // Phase is left as is; IDLE will retry the step.
                            ps_err <= 1'b1;
                            state  <= IDLE;
                            cnt    <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mmcm_phase_cntr.sv
// Bench for mmcm_phase_cntr: MMCM psdone model, scoreboard of expected
// steps and completions, directed scenarios plus random target walks.
module tb_mmcm_phase_cntr;

    localparam int W       = 8;
    localparam int TIMEOUT = 31;
    localparam int LAT     = 12;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                locked = 1'b0;
    logic                ps_we = 1'b0;
    logic signed [W-1:0] ps_target = '0;
    logic signed [W-1:0] ps_phase;
    logic                ps_ready;
    logic                ps_err;
    logic                psen;
    logic                psincdec;
    logic                psdone = 1'b0;

    mmcm_phase_cntr #(
        .PHASE_WIDTH   (W),
        .PSDONE_TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .locked   (locked),
        .ps_we    (ps_we),
        .ps_target(ps_target),
        .ps_phase (ps_phase),
        .ps_ready (ps_ready),
        .ps_err   (ps_err),
        .psen     (psen),
        .psincdec (psincdec),
        .psdone   (psdone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        bit inc;
        int phase;
    } step_t;

    step_t step_q[$];
    int    ready_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    bit    suppress = 1'b0;
    int    model_phase = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MMCM model: psdone for one cycle, LAT cycles after the psen cycle.
    initial begin
        int pend;
        pend = 0;
        forever begin
            @(negedge clk);
            psdone = 1'b0;
            if (rst) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) psdone = 1'b1;
                end
                if (psen && !suppress) pend = LAT;
            end
        end
    end

    // Monitor: every psen pulse and every ps_ready rise is matched against the queues.
    initial begin
        bit    prev_psen;
        bit    prev_ready;
        step_t s;
        prev_psen  = 1'b0;
        prev_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (psen) begin
                    check("psen_back_to_back", int'(prev_psen), 0);
                    check("psen_while_locked", int'(locked), 1);
                    if (step_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_psen: psen=1 at phase %0d, expected no step (t=%0t)",
                                 ps_phase, $time);
                    end else begin
                        s = step_q.pop_front();
                        check("psincdec", int'(psincdec), int'(s.inc));
                        check("phase_before_step", int'(ps_phase), s.phase);
                    end
                end
                if (ps_ready && !prev_ready) begin
                    if (ready_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_ready: ps_ready rose at phase %0d, expected none (t=%0t)",
                                 ps_phase, $time);
                    end else begin
                        check("ready_phase", int'(ps_phase), ready_q.pop_front());
                        check("steps_left_at_ready", step_q.size(), 0);
                    end
                end
            end
            prev_psen  = psen;
            prev_ready = ps_ready;
        end
    end

    // Reference: a move between settled phases is |to-from| unit steps toward
    // the target, then one completion at the target.
    task automatic push_move(input int from, input int to);
        step_t s;
        int    p;
        p = from;
        while (p != to) begin
            s.inc   = (to > from);
            s.phase = p;
            step_q.push_back(s);
            p = (to > from) ? p + 1 : p - 1;
        end
        ready_q.push_back(to);
    endtask

    task automatic push_step(input bit inc, input int phase);
        step_t s;
        s.inc   = inc;
        s.phase = phase;
        step_q.push_back(s);
    endtask

    task automatic write_target(input int t);
        @(posedge clk);
        #1;
        ps_we     = 1'b1;
        ps_target = W'(t);
        @(posedge clk);
        #1;
        ps_we = 1'b0;
    endtask

    task automatic wait_settle(input string name, input int budget);
        int n;
        n = 0;
        while ((step_q.size() != 0 || ready_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (step_q.size() != 0 || ready_q.size() != 0) begin
            n_err++;
            $display("FAIL %s: %0d steps and %0d completions outstanding after %0d cycles",
                     name, step_q.size(), ready_q.size(), n);
            step_q.delete();
            ready_q.delete();
        end
    endtask

    task automatic wait_psen(input string name, input int budget, output int c);
        int n;
        n = 0;
        c = -1;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (psen) begin
                c = cyc;
                break;
            end
        end
        n_cmp++;
        if (c < 0) begin
            n_err++;
            $display("FAIL %s: no psen within %0d cycles", name, budget);
        end
    endtask

    task automatic move_to(input int t);
        int d;
        if (t != model_phase) begin
            d = (t > model_phase) ? t - model_phase : model_phase - t;
            push_move(model_phase, t);
            write_target(t);
            wait_settle("move_settle", 16 * d + 60);
            model_phase = t;
            check("settled_phase", int'(ps_phase), t);
            check("settled_ready", int'(ps_ready), 1);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;
        int n;

        // Reset values.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_phase", int'(ps_phase), 0);
        check("rst_psen", int'(psen), 0);
        check("rst_psincdec", int'(psincdec), 0);
        check("rst_err", int'(ps_err), 0);
        check("rst_ready", int'(ps_ready), 0);

        // Lock after 5 cycles with no write: ready at phase 0, no steps.
        @(posedge clk);
        #1 rst = 1'b0;
        ready_q.push_back(0);
        repeat (5) @(posedge clk);
        #1 locked = 1'b1;
        wait_settle("lock_ready", 30);
        repeat (20) @(negedge clk);
        check("lock_phase", int'(ps_phase), 0);
        check("lock_ready_level", int'(ps_ready), 1);

        // +3 with latency check: psen in the second cycle after ps_we.
        push_move(0, 3);
        write_target(3);
        @(negedge clk);
        check("latency_cycle1_psen", int'(psen), 0);
        @(negedge clk);
        check("latency_cycle2_psen", int'(psen), 1);
        wait_settle("move_plus3", 100);
        model_phase = 3;
        check("phase_plus3", int'(ps_phase), 3);

        // Down to -2 (five decrements).
        move_to(-2);
        check("phase_minus2_raw", int'(ps_phase[7:0]), 8'hFE);

        // Retarget while the first step is in flight.
        move_to(0);
        push_step(1'b1, 0);
        ready_q.push_back(1);
        write_target(10);
        wait_psen("retarget_first_psen", 20, c0);
        repeat (3) @(negedge clk);
        write_target(1);
        wait_settle("retarget_settle", 60);
        model_phase = 1;
        repeat (40) @(negedge clk);
        check("retarget_phase", int'(ps_phase), 1);
        check("retarget_ready", int'(ps_ready), 1);

        // psdone suppressed: timeout, phase held, automatic retry, ps_we clears error.
        suppress = 1'b1;
        push_step(1'b1, 1);
        push_step(1'b1, 1);
        ready_q.push_back(2);
        write_target(2);
        wait_psen("timeout_psen", 20, c0);
        n  = 0;
        c1 = -1;
        while (n < 2 * TIMEOUT) begin
            @(negedge clk);
            n++;
            if (ps_err) begin
                c1 = cyc;
                break;
            end
        end
        check("timeout_err_delay", c1 - c0, TIMEOUT);
        check("timeout_phase_held", int'(ps_phase), 1);
        suppress = 1'b0;
        wait_settle("timeout_retry", 80);
        model_phase = 2;
        check("retry_phase", int'(ps_phase), 2);
        check("err_sticky", int'(ps_err), 1);
        write_target(2);
        @(negedge clk);
        check("err_cleared_by_we", int'(ps_err), 0);

        // Lose lock mid WAIT_DONE at phase 4 heading for 6.
        move_to(4);
        push_step(1'b1, 4);
        write_target(6);
        wait_psen("unlock_psen", 20, c0);
        repeat (4) @(negedge clk);
        locked = 1'b0;
        @(negedge clk);
        check("unlock_phase_zero", int'(ps_phase), 0);
        check("unlock_psen_low", int'(psen), 0);
        model_phase = 0;
        repeat (20) @(negedge clk);
        check("unlocked_phase_still_zero", int'(ps_phase), 0);
        push_move(0, 6);
        locked = 1'b1;
        wait_settle("relock_walk", 16 * 6 + 60);
        model_phase = 6;
        check("relock_phase", int'(ps_phase), 6);

        // Range extremes: no wrap at either end.
        move_to(127);
        move_to(-128);
        move_to(0);

        // Random targets.
        repeat (8) begin
            move_to(int'($urandom_range(0, 60)) - 30);
        end

        repeat (20) @(negedge clk);
        check("final_steps_queue", step_q.size(), 0);
        check("final_ready_queue", ready_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
